// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL reset pulse, lock qualification and system reset release on refclk
module pll_reset_sequencer #(
    parameter int RST_PULSE_CYCLES    = 10,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int LOCK_STABLE_CYCLES  = 1000,
    parameter int MAX_RETRIES         = 3,
    localparam int RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
    input  logic               refclk,
    input  logic               rst,
    input  logic               pll_locked,
    input  logic               relock_req,
    output logic               pll_rst,
    output logic               sys_rst,
    output logic               ready,
    output logic               fault,
    output logic [RETRY_W-1:0] retry_count
);

    localparam int CNT_MAX_TS = (LOCK_TIMEOUT_CYCLES > LOCK_STABLE_CYCLES) ?
                                LOCK_TIMEOUT_CYCLES : LOCK_STABLE_CYCLES;
    localparam int CNT_MAX    = (CNT_MAX_TS > RST_PULSE_CYCLES) ? CNT_MAX_TS : RST_PULSE_CYCLES;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

    typedef enum logic [2:0] {
        RESET_PLL,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAULT
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               sync1_q, sync1_d;
    logic               locked_s_q, locked_s_d;
    logic               pll_rst_q, pll_rst_d;
    logic               sys_rst_q, sys_rst_d;
    logic               ready_q, ready_d;
    logic               fault_q, fault_d;

    always_comb begin
        sync1_d    = pll_locked;
        locked_s_d = sync1_q;
        state_d    = state_q;
        retry_d    = retry_q;
        cnt_d      = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

        case (state_q)
            RESET_PLL: begin
                if (cnt_q >= RST_LAST) begin
                    state_d = WAIT_LOCK;
                end
            end
            WAIT_LOCK: begin
                if (locked_s_q) begin
                    state_d = STABLE;
                end else if (cnt_q >= TIMEOUT_LAST) begin
                    if (retry_q == RETRY_MAX) begin
                        state_d = FAULT;
                    end else begin
                        retry_d = retry_q + 1'b1;
                        state_d = RESET_PLL;
                    end
                end
            end
            STABLE: begin
                // A lock dropout here is a glitch, not a failed attempt.
                if (!locked_s_q) begin
                    state_d = WAIT_LOCK;
                end else if (cnt_q >= STABLE_LAST) begin
                    state_d = RUN;
                    retry_d = '0;
                end
            end
            RUN: begin
                if (!locked_s_q || relock_req) begin
                    state_d = RESET_PLL;
                end
            end
            FAULT: begin
                if (relock_req) begin
                    state_d = RESET_PLL;
                    retry_d = '0;
                end
            end
            default: begin
                state_d = RESET_PLL;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end

        // Outputs are decoded from the next state so they line up with the state register.
        pll_rst_d = (state_d == RESET_PLL) || (state_d == FAULT);
        sys_rst_d = (state_d != RUN);
        ready_d   = (state_d == RUN);
        fault_d   = (state_d == FAULT);
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q    <= RESET_PLL;
            cnt_q      <= '0;
            retry_q    <= '0;
            sync1_q    <= 1'b0;
            locked_s_q <= 1'b0;
            pll_rst_q  <= 1'b1;
            sys_rst_q  <= 1'b1;
            ready_q    <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            retry_q    <= retry_d;
            sync1_q    <= sync1_d;
            locked_s_q <= locked_s_d;
            pll_rst_q  <= pll_rst_d;
            sys_rst_q  <= sys_rst_d;
            ready_q    <= ready_d;
            fault_q    <= fault_d;
        end
    end

    assign pll_rst     = pll_rst_q;
    assign sys_rst     = sys_rst_q;
    assign ready       = ready_q;
    assign fault       = fault_q;
    assign retry_count = retry_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - vector table, corner sequences and random stimulus against a phase model
module tb_pll_reset_sequencer;

    localparam int RPC  = 4;
    localparam int LTC  = 32;
    localparam int LSC  = 8;
    localparam int MAXR = 2;

    // {pll_rst, sys_rst, ready, fault}
    localparam logic [3:0] RS = 4'b1100;
    localparam logic [3:0] WT = 4'b0100;
    localparam logic [3:0] RN = 4'b0010;
    localparam logic [3:0] FT = 4'b1101;

    localparam int PH_PULSE = 0;
    localparam int PH_WAIT  = 1;
    localparam int PH_STAB  = 2;
    localparam int PH_RUN   = 3;
    localparam int PH_FAULT = 4;

    logic       refclk     = 1'b0;
    logic       rst        = 1'b0;
    logic       pll_locked = 1'b0;
    logic       relock_req = 1'b0;
    logic       pll_rst, sys_rst, ready, fault;
    logic [1:0] retry_count;
    logic [5:0] dut_out;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       locked;
        logic       req;
        int         cycles;
        logic [5:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[$];

    int m_phase = PH_PULSE;
    int m_left  = RPC;
    int m_fails = 0;
    bit lq[$];

    pll_reset_sequencer #(
        .RST_PULSE_CYCLES   (RPC),
        .LOCK_TIMEOUT_CYCLES(LTC),
        .LOCK_STABLE_CYCLES (LSC),
        .MAX_RETRIES        (MAXR)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .relock_req (relock_req),
        .pll_rst    (pll_rst),
        .sys_rst    (sys_rst),
        .ready      (ready),
        .fault      (fault),
        .retry_count(retry_count)
    );

    assign dut_out = {pll_rst, sys_rst, ready, fault, retry_count};

    always #5 refclk = ~refclk;

    function automatic int phase_len(input int ph);
        case (ph)
            PH_PULSE: return RPC;
            PH_WAIT:  return LTC;
            PH_STAB:  return LSC;
            default:  return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_phase = PH_PULSE;
        m_left  = RPC;
        m_fails = 0;
        lq      = '{1'b0, 1'b0};
    endtask

    // lq holds the last two sampled lock values, oldest first: the oldest is what the FSM sees.
    task automatic model_clock();
        bit ls;
        int nxt;
        ls  = lq[0];
        lq.push_back(pll_locked);
        void'(lq.pop_front());
        nxt = m_phase;
        case (m_phase)
            PH_PULSE: begin
                m_left--;
                if (m_left == 0) nxt = PH_WAIT;
            end
            PH_WAIT: begin
                if (ls) begin
                    nxt = PH_STAB;
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        if (m_fails == MAXR) begin
                            nxt = PH_FAULT;
                        end else begin
                            m_fails++;
                            nxt = PH_PULSE;
                        end
                    end
                end
            end
            PH_STAB: begin
                if (!ls) begin
                    nxt = PH_WAIT;
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_fails = 0;
                        nxt = PH_RUN;
                    end
                end
            end
            PH_RUN: begin
                if (!ls || relock_req) nxt = PH_PULSE;
            end
            default: begin
                if (relock_req) begin
                    m_fails = 0;
                    nxt = PH_PULSE;
                end
            end
        endcase
        if (nxt != m_phase) begin
            m_phase = nxt;
            m_left  = phase_len(nxt);
        end
    endtask

    function automatic logic [5:0] model_out();
        logic [1:0] rc;
        rc = 2'(m_fails);
        return {(m_phase == PH_PULSE) || (m_phase == PH_FAULT), m_phase != PH_RUN,
                m_phase == PH_RUN, m_phase == PH_FAULT, rc};
    endfunction

    task automatic chk(input string nm, input logic [5:0] got, input logic [5:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got {pll_rst,sys_rst,ready,fault,retry}=%b expected %b at %0t",
                     nm, got, exp, $time);
        end
    endtask

    task automatic step(input string nm);
        @(posedge refclk);
        if (!rst) model_clock();
        @(negedge refclk);
        chk({"model:", nm}, dut_out, model_out());
    endtask

    task automatic add(input logic l, input logic r, input int n, input logic [3:0] code,
                       input int rc, input string nm);
        vec_t v;
        v.locked = l;
        v.req    = r;
        v.cycles = n;
        v.exp    = {code, 2'(rc)};
        v.name   = nm;
        vecs.push_back(v);
    endtask

    initial begin
        int run_left;

        // Nominal, loss of lock, relock from RUN
        add(0, 0,  3, RS, 0, "pulse_high");
        add(0, 0,  1, WT, 0, "pulse_fall");
        add(0, 0,  5, WT, 0, "wait_unlocked");
        add(1, 0, 10, WT, 0, "lock_edge10");
        add(1, 0,  1, RN, 0, "lock_ready_edge11");
        add(1, 0, 20, RN, 0, "run_hold");
        add(0, 0,  2, RN, 0, "loss_sync_delay");
        add(0, 0,  1, RS, 0, "loss_edge3");
        add(0, 0,  3, RS, 0, "loss_pulse_high");
        add(1, 0,  1, WT, 0, "loss_pulse_fall");
        add(1, 0, 10, RN, 0, "loss_relock_run");
        add(1, 1,  1, RS, 0, "req_in_run");
        add(1, 1,  3, RS, 0, "req_in_pulse");
        add(1, 0,  1, WT, 0, "req_pulse_fall");
        add(1, 1,  1, WT, 0, "req_in_wait_locked");
        add(1, 0,  7, WT, 0, "stable_7");
        add(1, 0,  1, RN, 0, "stable_8");
        // Glitch in STABLE
        add(0, 0,  3, RS, 0, "glitch_loss");
        add(0, 0,  4, WT, 0, "glitch_pulse");
        add(1, 0,  3, WT, 0, "glitch_lock");
        add(1, 0,  5, WT, 0, "glitch_stable5");
        add(0, 0,  2, WT, 0, "glitch_low");
        add(1, 0,  3, WT, 0, "glitch_restore");
        add(1, 0,  7, WT, 0, "glitch_fresh7");
        add(1, 0,  1, RN, 0, "glitch_fresh8");
        // Never lock, then FAULT recovery
        add(0, 0,  3, RS, 0, "nl_enter");
        add(0, 0,  4, WT, 0, "nl_pulse1");
        add(0, 0, 31, WT, 0, "nl_wait1");
        add(0, 0,  1, RS, 1, "nl_timeout1");
        add(0, 0, 36, RS, 2, "nl_timeout2");
        add(0, 0, 35, WT, 2, "nl_wait3");
        add(0, 0,  1, FT, 2, "nl_fault");
        add(1, 0, 20, FT, 2, "fault_ignores_lock");
        add(0, 1,  1, RS, 0, "fault_relock");
        add(0, 0,  4, WT, 0, "rec_pulse");
        add(0, 1,  3, WT, 0, "req_in_wait");
        add(1, 0, 10, WT, 0, "rec_lock10");
        add(1, 0,  1, RN, 0, "rec_ready");

        #1;
        rst = 1'b1;
        model_reset();
        repeat (3) @(negedge refclk);
        chk("reset_values", dut_out, {RS, 2'd0});
        chk("model:reset", dut_out, model_out());
        rst = 1'b0;

        foreach (vecs[i]) begin
            pll_locked = vecs[i].locked;
            relock_req = vecs[i].req;
            for (int c = 0; c < vecs[i].cycles; c++) begin
                step(vecs[i].name);
                relock_req = 1'b0;
            end
            chk(vecs[i].name, dut_out, vecs[i].exp);
        end

        // Asynchronous reset between edges while in RUN
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        chk("async_assert", dut_out, {RS, 2'd0});
        @(negedge refclk);
        rst = 1'b0;
        repeat (3) step("post_rst");
        chk("post_rst_pulse", dut_out, {RS, 2'd0});
        step("post_rst");
        chk("post_rst_fall", dut_out, {WT, 2'd0});
        repeat (LSC) step("post_rst");
        chk("post_rst_stable", dut_out, {WT, 2'd0});
        step("post_rst");
        chk("post_rst_ready", dut_out, {RN, 2'd0});

        run_left = 0;
        for (int i = 0; i < 3000; i++) begin
            if (run_left == 0) begin
                pll_locked = ~pll_locked;
                if (pll_locked)
                    run_left = ($urandom_range(0, 2) == 0) ? $urandom_range(15, 60) : $urandom_range(1, 12);
                else
                    run_left = ($urandom_range(0, 4) == 0) ? $urandom_range(60, 160) : $urandom_range(1, 20);
            end
            run_left--;
            relock_req = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 599) == 0) begin
                #2;
                rst = 1'b1;
                model_reset();
                #1;
                chk("rand_async", dut_out, model_out());
                @(negedge refclk);
                rst = 1'b0;
            end
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Reset and lock sequencer for the board PLL (50 MHz reference in; 100 MHz and 1 MHz outputs). It pulses the PLL reset, waits for a qualified lock, then releases a system reset to downstream logic. It re-sequences on loss of lock or on software request, and retries a bounded number of times before declaring a fault. It runs entirely on the 50 MHz reference clock, so it works while the PLL outputs are dead.

## Interface
- RST_PULSE_CYCLES, 10: refclk cycles pll_rst is held high per attempt (≥1)
- LOCK_TIMEOUT_CYCLES, 50000: max cycles in WAIT_LOCK before an attempt fails (1 ms @ 50 MHz)
- LOCK_STABLE_CYCLES, 1000: consecutive synchronized-lock cycles required before release
- MAX_RETRIES, 3: failed attempts tolerated after the first before FAULT; retry_count width = clog2(MAX_RETRIES+1)
- refclk  in  1  free-running 50 MHz reference, sole clock
- rst  in  1  asynchronous, active-high reset
- pll_locked  in  1  PLL lock, asynchronous to refclk
- relock_req  in  1  single-cycle request to re-sequence; honoured in RUN and FAULT only
- pll_rst  out  1  PLL reset, active-high
- sys_rst  out  1  downstream reset, active-high, refclk-synchronous deassert; consumers re-synchronize into their own domains
- ready  out  1  high only in RUN
- fault  out  1  high only in FAULT
- retry_count  out  clog2(MAX_RETRIES+1)  failed attempts since last RUN/FAULT exit

## Operation
- pll_locked passes through a 2-flop synchronizer; the FSM uses only locked_s.
- All outputs are registered and decoded from the state register.
- Reset values (while rst=1): state=RESET_PLL, pll_rst=1, sys_rst=1, ready=0, fault=0, retry_count=0, counters 0.
- RESET_PLL: pll_rst=1, sys_rst=1. Count RST_PULSE_CYCLES edges, then go to WAIT_LOCK with counter cleared.
- WAIT_LOCK: pll_rst=0, sys_rst=1.
  - If locked_s=1, go to STABLE.
  - Else, on the LOCK_TIMEOUT_CYCLES-th cycle: if retry_count==MAX_RETRIES, go to FAULT; otherwise retry_count+1 and go to RESET_PLL.
- STABLE: pll_rst=0, sys_rst=1. Count cycles with locked_s=1.
  - If locked_s=0 at any point, go back to WAIT_LOCK with a fresh timeout. This is not a retry.
  - On reaching LOCK_STABLE_CYCLES, go to RUN.
- RUN: sys_rst=0, ready=1. On entry, clear retry_count.
  - locked_s=0 or relock_req=1 goes to RESET_PLL; sys_rst=1 and ready=0 on the next edge.
  - If both occur in the same cycle, behaviour is identical.
- FAULT: pll_rst=1, sys_rst=1, fault=1, retry_count holds its value.
  - relock_req clears retry_count and goes to RESET_PLL.
  - pll_locked is ignored.
- relock_req is ignored in RESET_PLL, WAIT_LOCK and STABLE.
- Counters saturate and never wrap. Each counter is cleared on every state entry.

## Timing
- Synchronizer latency is 2 cycles, pll_locked to locked_s.
- rst deassert → pll_rst falls: RST_PULSE_CYCLES edges.
- pll_locked rise (held) → ready/sys_rst release: 2 + 1 + LOCK_STABLE_CYCLES edges.
- pll_locked fall in RUN → sys_rst=1, ready=0: 3 edges, since pll_locked is sampled and passes the 2-flop synchronizer before the state-register edge.
- relock_req in RUN → sys_rst=1: 1 edge.
- rst assertion at any time forces the reset values immediately, with no clock needed. Deassertion restarts the sequence from RESET_PLL with retry_count=0.

## Test plan
Parameters: RST_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=32, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2.
- Nominal: release rst; pll_locked rises 5 cycles after pll_rst falls → pll_rst high 4 cycles; ready=1 and sys_rst=0 exactly 11 cycles after pll_locked rise; retry_count=0.
- Never lock: pll_locked=0 throughout → 3 pll_rst pulses of 4 cycles, each 32 cycles apart; then fault=1, retry_count=2, pll_rst stuck high; ready never asserts.
- Glitch in STABLE: lock, drop pll_locked for 2 cycles after 5 stable cycles, restore → no retry (retry_count=0); ready delayed until 8 fresh consecutive locked_s cycles.
- Loss of lock in RUN: drop pll_locked → sys_rst=1, ready=0 after 3 edges; new 4-cycle pll_rst pulse; re-lock → RUN with retry_count=0.
- FAULT recovery: from the never-lock fault, pulse relock_req with pll_locked then toggling normally → fault=0, retry_count=0, nominal sequence to ready. Also pulse relock_req during WAIT_LOCK → no effect.
- Async reset mid-RUN: assert rst between clock edges → pll_rst=1, sys_rst=1, ready=0 before the next edge; deassert → full sequence from RESET_PLL.
